// File: rtl/aibcr3_dcc_pkg.sv
// Shared definitions for the DCC delay-line controllers: FSM encoding,
// code width and the binary-to-Gray conversion used on the line control bus.
package aibcr3_dcc_pkg;

    localparam int CODE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAR_SETTLE,
        ST_SAR_SAMPLE,
        ST_TRK_SETTLE,
        ST_TRK_SAMPLE
    } dcc_state_e;

    function automatic logic [CODE_W-1:0] bin2gry(input logic [CODE_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/aibcr3_dcc_pdavg.sv
// Decision-window timer: SETTLE_CYC idle cycles after start, then 2^AVG_LOG2
// phase-detector samples; late is a strict majority of ones (a tie is early).
module aibcr3_dcc_pdavg #(
    parameter int SETTLE_CYC = 16,
    parameter int AVG_LOG2   = 3
) (
    input  logic CLK,
    input  logic RST,
    input  logic start,
    input  logic pd_late,
    output logic settle_done,
    output logic done,
    output logic late
);

    localparam int N    = 1 << AVG_LOG2;
    localparam int LAST = SETTLE_CYC + N - 1;

    logic [8:0] cnt;
    logic [5:0] ones;
    logic [6:0] ones_tot;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt  <= '0;
            ones <= '0;
        end else if (start) begin
            cnt  <= '0;
            ones <= '0;
        end else if (cnt != 9'(LAST)) begin
            cnt <= cnt + 9'd1;
            if (cnt >= 9'(SETTLE_CYC) && pd_late)
                ones <= ones + 6'd1;
        end
    end

    // The final sample of the window is folded in combinationally so the
    // decision lands on the edge that ends the window.
    assign ones_tot    = {1'b0, ones} + {6'd0, pd_late};
    assign settle_done = (cnt == 9'(SETTLE_CYC - 1));
    assign done        = (cnt == 9'(LAST));
    assign late        = ({ones_tot, 1'b0} > 8'(N));

endmodule

// File: rtl/aibcr3_dcc_crsctrl.sv
// Coarse-delay lock controller: 8-step SAR search over the 256-tap line, then
// hysteresis-filtered +/-1 tracking; drives a registered Gray code.
module aibcr3_dcc_crsctrl
    import aibcr3_dcc_pkg::*;
#(
    parameter int SETTLE_CYC = 16,
    parameter int AVG_LOG2   = 3,
    parameter int TRK_HYST   = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              dcc_en,
    input  logic              pd_late,
    input  logic              ovr_en,
    input  logic [CODE_W-1:0] ovr_code,
    output logic [CODE_W-1:0] crs_gry,
    output logic [CODE_W-1:0] crs_bin,
    output logic              busy,
    output logic              lock,
    output logic              sat_hi,
    output logic              sat_lo
);

    localparam logic signed [4:0] HYST_P = 5'(TRK_HYST);
    localparam logic signed [4:0] HYST_N = -HYST_P;

    dcc_state_e        state, state_nxt;
    logic [2:0]        bit_idx, bit_nxt;
    logic signed [4:0] hyst, hyst_nxt, hyst_tmp;
    logic [CODE_W-1:0] code_nxt;
    logic              busy_nxt, lock_nxt, sat_hi_nxt, sat_lo_nxt;
    logic              pd_start, settle_done, win_done, win_late;

    aibcr3_dcc_pdavg #(
        .SETTLE_CYC (SETTLE_CYC),
        .AVG_LOG2   (AVG_LOG2)
    ) u_pdavg (
        .CLK         (CLK),
        .RST         (RST),
        .start       (pd_start),
        .pd_late     (pd_late),
        .settle_done (settle_done),
        .done        (win_done),
        .late        (win_late)
    );

    // Window timer restarts on every entry into a settle state and is held clear in IDLE.
    assign pd_start = state_nxt == ST_IDLE ||
                      ((state_nxt == ST_SAR_SETTLE || state_nxt == ST_TRK_SETTLE) &&
                       state_nxt != state);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (ovr_en || !dcc_en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:       state_nxt = ST_SAR_SETTLE;
                ST_SAR_SETTLE: if (settle_done) state_nxt = ST_SAR_SAMPLE;
                ST_SAR_SAMPLE: if (win_done)
                                   state_nxt = (bit_idx == 3'd0) ? ST_TRK_SETTLE : ST_SAR_SETTLE;
                ST_TRK_SETTLE: if (settle_done) state_nxt = ST_TRK_SAMPLE;
                ST_TRK_SAMPLE: if (win_done) state_nxt = ST_TRK_SETTLE;
                default:       state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        code_nxt   = crs_bin;
        bit_nxt    = bit_idx;
        hyst_nxt   = hyst;
        hyst_tmp   = hyst;
        busy_nxt   = busy;
        lock_nxt   = lock;
        sat_hi_nxt = sat_hi;
        sat_lo_nxt = sat_lo;
        if (ovr_en || !dcc_en) begin
            if (ovr_en) code_nxt = ovr_code;
            bit_nxt    = 3'd7;
            hyst_nxt   = '0;
            busy_nxt   = 1'b0;
            lock_nxt   = 1'b0;
            sat_hi_nxt = 1'b0;
            sat_lo_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    code_nxt = 8'h80;
                    bit_nxt  = 3'd7;
                    hyst_nxt = '0;
                    busy_nxt = 1'b1;
                    lock_nxt = 1'b0;
                end
                ST_SAR_SAMPLE: if (win_done) begin
                    if (win_late) code_nxt[bit_idx] = 1'b0;
                    if (bit_idx != 3'd0) begin
                        code_nxt[bit_idx - 3'd1] = 1'b1;
                        bit_nxt = bit_idx - 3'd1;
                    end else begin
                        lock_nxt = 1'b1;
                        hyst_nxt = '0;
                    end
                end
                ST_TRK_SAMPLE: if (win_done) begin
                    hyst_tmp = win_late ? hyst - 5'sd1 : hyst + 5'sd1;
                    hyst_nxt = hyst_tmp;
                    if (hyst_tmp == HYST_P) begin
                        hyst_nxt = '0;
                        if (crs_bin == '1) begin
                            sat_hi_nxt = 1'b1;
                        end else begin
                            code_nxt   = crs_bin + 8'd1;
                            sat_lo_nxt = 1'b0;
                        end
                    end else if (hyst_tmp == HYST_N) begin
                        hyst_nxt = '0;
                        if (crs_bin == '0) begin
                            sat_lo_nxt = 1'b1;
                        end else begin
                            code_nxt   = crs_bin - 8'd1;
                            sat_hi_nxt = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Gray and binary codes load on the same edge so the line never sees skew.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            crs_bin <= '0;
            crs_gry <= '0;
            bit_idx <= 3'd7;
            hyst    <= '0;
            busy    <= 1'b0;
            lock    <= 1'b0;
            sat_hi  <= 1'b0;
            sat_lo  <= 1'b0;
        end else begin
            crs_bin <= code_nxt;
            crs_gry <= bin2gry(code_nxt);
            bit_idx <= bit_nxt;
            hyst    <= hyst_nxt;
            busy    <= busy_nxt;
            lock    <= lock_nxt;
            sat_hi  <= sat_hi_nxt;
            sat_lo  <= sat_lo_nxt;
        end
    end

endmodule

// File: tb/tb_aibcr3_dcc_crsctrl.sv
// Bench for the coarse-delay controller: a detector model drives pd_late from
// the code, and a scoreboard of expected code changes is checked on every edge.
module tb_aibcr3_dcc_crsctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       dcc_en = 1'b0;
    logic       pd_late = 1'b0;
    logic       ovr_en = 1'b0;
    logic [7:0] ovr_code = 8'h00;
    logic [7:0] crs_gry, crs_bin;
    logic       busy, lock, sat_hi, sat_lo;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         tgt = 0;
    bit         alt_mode = 1'b0;
    bit         sb_on = 1'b0;
    bit         one_bit_on = 1'b0;
    bit         changed = 1'b0;
    logic [7:0] prev_bin = 8'h00;
    logic [7:0] prev_gry = 8'h00;
    logic [7:0] exp_q[$];

    aibcr3_dcc_crsctrl #(
        .SETTLE_CYC (16),
        .AVG_LOG2   (3),
        .TRK_HYST   (4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .dcc_en   (dcc_en),
        .pd_late  (pd_late),
        .ovr_en   (ovr_en),
        .ovr_code (ovr_code),
        .crs_gry  (crs_gry),
        .crs_bin  (crs_bin),
        .busy     (busy),
        .lock     (lock),
        .sat_hi   (sat_hi),
        .sat_lo   (sat_lo)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] gray_of(input logic [7:0] b);
        logic [7:0] g;
        g[7] = b[7];
        for (int i = 0; i < 7; i++) g[i] = b[i] ^ b[i+1];
        return g;
    endfunction

    // Expected SAR code changes for a detector that is late iff code > t.
    function automatic void push_sar(input int t);
        logic [7:0] c, n;
        c = 8'h80;
        exp_q.push_back(c);
        for (int i = 7; i >= 0; i--) begin
            n = c;
            if (int'(c) > t) n[i] = 1'b0;
            if (i > 0) n[i-1] = 1'b1;
            if (n != c) exp_q.push_back(n);
            c = n;
        end
    endfunction

    task automatic step();
        logic [7:0] e;
        @(posedge CLK);
        #1;
        cyc++;
        changed = (crs_bin !== prev_bin);
        if (changed && sb_on) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL code_change cyc=%0d got=%02h expected=no change", cyc, crs_bin);
            end else begin
                e = exp_q.pop_front();
                if (crs_bin !== e || crs_gry !== gray_of(e)) begin
                    failures++;
                    $display("FAIL code_seq cyc=%0d got bin=%02h gry=%02h expected bin=%02h gry=%02h",
                             cyc, crs_bin, crs_gry, e, gray_of(e));
                end
            end
            if (one_bit_on) begin
                checks++;
                if ($countones(crs_gry ^ prev_gry) != 1) begin
                    failures++;
                    $display("FAIL gray_one_bit cyc=%0d got %02h->%02h expected one bit flip",
                             cyc, prev_gry, crs_gry);
                end
            end
        end
        prev_bin = crs_bin;
        prev_gry = crs_gry;
        if (alt_mode) pd_late = ~pd_late;
        else          pd_late = (int'(crs_bin) > tgt);
    endtask

    task automatic do_reset();
        sb_on = 1'b0;
        RST   = 1'b1;
        #2;
        RST   = 1'b0;
        exp_q.delete();
        prev_bin = 8'h00;
        prev_gry = 8'h00;
        sb_on = 1'b1;
    endtask

    // Runs one SAR from the next edge and checks lock timing and final code.
    task automatic start_sar(input string name, input int t, input bit alt, input logic [7:0] fin);
        int k, n;
        tgt      = t;
        alt_mode = alt;
        push_sar(alt ? 255 : t);
        k = cyc + 1;
        n = 0;
        while (lock !== 1'b1 && n < 400) begin
            step();
            n++;
            if (n == 100) begin
                checks++;
                if (busy !== 1'b1 || lock !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_busy got busy=%b lock=%b expected busy=1 lock=0", name, busy, lock);
                end
            end
        end
        checks++;
        if (lock !== 1'b1 || cyc != k + 192) begin
            failures++;
            $display("FAIL %s_lock_time got lock=%b at edge %0d expected lock=1 at edge %0d",
                     name, lock, cyc - k, 192);
        end
        checks++;
        if (crs_bin !== fin || crs_gry !== gray_of(fin)) begin
            failures++;
            $display("FAIL %s_final got bin=%02h gry=%02h expected bin=%02h gry=%02h",
                     name, crs_bin, crs_gry, fin, gray_of(fin));
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_sb_left got %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #1 RST = 1'b1;
        #2;
        checks++;
        if ({crs_gry, crs_bin, busy, lock, sat_hi, sat_lo} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs got gry=%02h bin=%02h busy=%b lock=%b sat=%b%b expected all 0",
                     crs_gry, crs_bin, busy, lock, sat_hi, sat_lo);
        end
        @(posedge CLK);
        @(posedge CLK);
        #3 RST = 1'b0;
        sb_on = 1'b1;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || crs_bin !== 8'h00) begin
            failures++;
            $display("FAIL idle_hold got busy=%b bin=%02h expected busy=0 bin=00", busy, crs_bin);
        end
    endtask

    task automatic test_sar_lock();
        dcc_en = 1'b1;
        start_sar("sar_5a", 8'h5A, 1'b0, 8'h5A);
        checks++;
        if (crs_gry !== 8'h77) begin
            failures++;
            $display("FAIL sar_5a_gray got=%02h expected=77", crs_gry);
        end
    endtask

    task automatic test_tracking();
        int last, n;
        tgt        = 8'h5C;
        one_bit_on = 1'b1;
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(8'h5B); exp_q.push_back(8'h5C); exp_q.push_back(8'h5D);
        exp_q.push_back(8'h5C); exp_q.push_back(8'h5D); exp_q.push_back(8'h5C);
        last = cyc;
        for (int s = 0; s < 6; s++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (!changed && n < 200);
            checks++;
            if (!changed || cyc - last != 96) begin
                failures++;
                $display("FAIL trk_interval step=%0d got %0d cycles changed=%b expected 96",
                         s, cyc - last, changed);
            end
            last = cyc;
        end
        one_bit_on = 1'b0;
    endtask

    task automatic test_override();
        ovr_en   = 1'b1;
        ovr_code = 8'h33;
        exp_q.push_back(8'h33);
        step();
        checks++;
        if (crs_bin !== 8'h33 || crs_gry !== 8'h2A || lock !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ovr_apply got bin=%02h gry=%02h lock=%b busy=%b expected 33 2a 0 0",
                     crs_bin, crs_gry, lock, busy);
        end
        ovr_code = 8'hC4;
        exp_q.push_back(8'hC4);
        step();
        checks++;
        if (crs_gry !== 8'hA6) begin
            failures++;
            $display("FAIL ovr_follow got gry=%02h expected a6", crs_gry);
        end
        repeat (3) step();
        ovr_en = 1'b0;
        start_sar("sar_after_ovr", 8'h5A, 1'b0, 8'h5A);
    endtask

    task automatic test_reset_mid();
        int k;
        dcc_en = 1'b0;
        step();
        dcc_en = 1'b1;
        tgt = 8'h5A;
        push_sar(8'h5A);
        k = cyc + 1;
        while (cyc < k + 80) step();
        checks++;
        if (crs_bin !== 8'h50) begin
            failures++;
            $display("FAIL mid_sar_code got=%02h expected=50", crs_bin);
        end
        #2;
        sb_on = 1'b0;
        RST   = 1'b1;
        #1;
        checks++;
        if ({crs_gry, crs_bin, busy, lock, sat_hi, sat_lo} !== 20'h0) begin
            failures++;
            $display("FAIL async_reset got gry=%02h bin=%02h busy=%b lock=%b expected all 0",
                     crs_gry, crs_bin, busy, lock);
        end
        #2;
        RST = 1'b0;
        exp_q.delete();
        prev_bin = 8'h00;
        prev_gry = 8'h00;
        sb_on = 1'b1;
        start_sar("sar_after_rst", 8'h5A, 1'b0, 8'h5A);
    endtask

    task automatic test_sat_hi();
        do_reset();
        start_sar("sar_all_early", 255, 1'b0, 8'hFF);
        repeat (95) step();
        checks++;
        if (sat_hi !== 1'b0) begin
            failures++;
            $display("FAIL sat_hi_early got=%b expected=0", sat_hi);
        end
        step();
        checks++;
        if (sat_hi !== 1'b1 || crs_bin !== 8'hFF || lock !== 1'b1) begin
            failures++;
            $display("FAIL sat_hi_set got sat_hi=%b bin=%02h lock=%b expected 1 ff 1", sat_hi, crs_bin, lock);
        end
        tgt = -1;
        exp_q.push_back(8'hFE);
        repeat (96) step();
        checks++;
        if (sat_hi !== 1'b0 || crs_bin !== 8'hFE || sat_lo !== 1'b0) begin
            failures++;
            $display("FAIL sat_hi_clear got sat_hi=%b sat_lo=%b bin=%02h expected 0 0 fe", sat_hi, sat_lo, crs_bin);
        end
    endtask

    task automatic test_sat_lo();
        dcc_en = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || lock !== 1'b0 || sat_hi !== 1'b0 || crs_bin !== 8'hFE) begin
            failures++;
            $display("FAIL disable got busy=%b lock=%b sat_hi=%b bin=%02h expected 0 0 0 fe",
                     busy, lock, sat_hi, crs_bin);
        end
        dcc_en = 1'b1;
        start_sar("sar_all_late", -1, 1'b0, 8'h00);
        repeat (96) step();
        checks++;
        if (sat_lo !== 1'b1 || crs_bin !== 8'h00) begin
            failures++;
            $display("FAIL sat_lo_set got sat_lo=%b bin=%02h expected 1 00", sat_lo, crs_bin);
        end
        tgt = 255;
        exp_q.push_back(8'h01);
        repeat (96) step();
        checks++;
        if (sat_lo !== 1'b0 || crs_bin !== 8'h01) begin
            failures++;
            $display("FAIL sat_lo_clear got sat_lo=%b bin=%02h expected 0 01", sat_lo, crs_bin);
        end
    endtask

    task automatic test_tie();
        do_reset();
        start_sar("sar_tie", 255, 1'b1, 8'hFF);
        alt_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sar_lock();
        test_tracking();
        test_override();
        test_reset_mid();
        test_sat_hi();
        test_sat_lo();
        test_tie();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aibcr3_dcc_crsctrl.md
# aibcr3_dcc_crsctrl

Coarse-delay lock controller for the DCC coarse delay line. Runs an 8-step successive-approximation search over the 256-tap coarse line, driven by a phase-detector sample. It then tracks slow drift with hysteresis-filtered ±1 steps. Its output is the registered 8-bit Gray code that drives the line's `gry[10:3]` input, so tracking steps change exactly one control bit per update.

## Interface
Parameters:
- `SETTLE_CYC`, 16: cycles to wait after any code change before sampling (1..255)
- `AVG_LOG2`, 3: log2 of phase-detector samples per decision window (N = 2^AVG_LOG2, 1..5)
- `TRK_HYST`, 4: net same-direction windows required for one tracking step (1..15)

Ports:
- `CLK` in 1: controller clock
- `RST` in 1: reset, asynchronous, active-high
- `dcc_en` in 1: run enable; low forces IDLE
- `pd_late` in 1: phase-detector result, already synchronous to `CLK`; 1 = delayed edge late (too much delay)
- `ovr_en` in 1: manual override of the code
- `ovr_code` in 8: binary override code
- `crs_gry` out 8: Gray code to the coarse line; bit 7 maps to `gry[10]`
- `crs_bin` out 8: binary code, debug/observability
- `busy` out 1: search or tracking active
- `lock` out 1: SAR search complete; tracking active
- `sat_hi` out 1: tracking requested +1 at code 0xFF
- `sat_lo` out 1: tracking requested −1 at code 0x00

## Operation
- States: IDLE, SAR_SETTLE, SAR_SAMPLE, TRK_SETTLE, TRK_SAMPLE.
- Reset: all outputs 0, state IDLE, bit index 7, hysteresis counter 0.
- IDLE → SAR_SETTLE when `dcc_en`=1 and `ovr_en`=0. On that edge: `crs_bin`←0x80, bit index i←7, `busy`←1, `lock`←0.
- SETTLE (SAR or TRK): count `SETTLE_CYC` cycles, then go to the matching SAMPLE state.
- SAMPLE: accumulate `pd_late` ones over N cycles. Window result is late iff 2·ones > N. A tie counts as early.
- SAR decision, on the edge ending the window:
  - If late, clear bit i.
  - If i>0, set bit i−1, decrement i, and return to SAR_SETTLE.
  - If i=0, assert `lock`, clear the hysteresis counter, and go to TRK_SETTLE.
- The SAR result is the largest code for which the detector reports early.
- TRK decision:
  - Late decrements the signed hysteresis counter; early increments it.
  - At +`TRK_HYST`: code+1 and counter←0. At −`TRK_HYST`: code−1 and counter←0.
  - Then return to TRK_SETTLE.
- Saturation:
  - A +1 request at 0xFF holds the code and sets `sat_hi`. A −1 request at 0x00 holds the code and sets `sat_lo`.
  - Each flag clears on the next successful step in the opposite direction, or on leaving tracking.
- `crs_gry` = `crs_bin` ^ (`crs_bin`>>1). It is registered together with `crs_bin`, with no cycle skew between them.
- `dcc_en` low in any state: IDLE on the next edge. `busy`, `lock`, `sat_*` and the counters clear; the code holds its last value.
- `ovr_en` high: `crs_bin`←`ovr_code` each cycle and the FSM is held in IDLE. On release with `dcc_en`=1, a fresh SAR starts on the next edge.
- Both `dcc_en` falling and `ovr_en` asserted in the same cycle: override wins for the code; the state still goes to IDLE.

## Timing
- All outputs are registered; no combinational path from input to output.
- One window takes `SETTLE_CYC`+N cycles (defaults: 24).
- With start at edge k, `lock` rises at edge k+8·(`SETTLE_CYC`+N) (defaults: k+192).
- Tracking step latency: at least `TRK_HYST`·(`SETTLE_CYC`+N) cycles between code changes.
- Override takes effect 1 cycle after `ovr_en`/`ovr_code` are sampled.
- `RST` asserted mid-operation clears all outputs asynchronously. Operation restarts from IDLE after deassertion.

## Structure
- Shared package `aibcr3_dcc_pkg` holds:
  - the FSM state encoding;
  - the 8-bit code width constant;
  - a `bin2gry` function, shared with the fine-delay controller.
- One sub-module, `aibcr3_dcc_pdavg`. It handles settle counting and N-sample accumulation: inputs start/`pd_late`, outputs done/late.
- The top level holds the FSM, the SAR/tracking code register, the hysteresis counter and the flags.

## Test plan
- Detector model `pd_late`=(code>0x5A), `dcc_en` rising at edge k:
  - `lock` rises at k+192.
  - `crs_bin`=0x5A, `crs_gry`=0x77.
  - SAR codes visited: 0x80, 0x40, 0x60, 0x50, 0x58, 0x5C, 0x5A, 0x5B.
- After lock, move the model target to 0x5C:
  - the code steps 0x5A→0x5B→0x5C, 96 cycles apart;
  - it then dithers within {0x5C, 0x5D};
  - each step changes exactly one `crs_gry` bit.
- `pd_late` held 0:
  - SAR ends at 0xFF;
  - `sat_hi`=1 after 4 further windows, with the code held at 0xFF;
  - `pd_late` then held 1 clears `sat_hi` on the step to 0xFE.
- Alternating `pd_late` per cycle (tie, N/2 ones): every window resolves early, so SAR ends at 0xFF.
- `RST` pulsed during SAR bit 4: outputs are 0 within the same cycle, with no edge needed. After release, a full SAR completes in 192 cycles.
- `ovr_en`=1 with `ovr_code`=0x33 during tracking:
  - `crs_bin`=0x33, `crs_gry`=0x2A, `lock`=0 one cycle later;
  - on release, a fresh SAR starts at 0x80.
